// File: rtl/rv32i_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Requester ids, FSM state encoding and default widths.
package rv32i_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   typedef enum logic {
      IDLE,
      RD_WAIT
   } arb_state_e;

endpackage

// File: rtl/rv32i_arb_pick.sv
// Priority pick between fetch and load/store with a starvation guard.
// Data wins unless fetch has waited through STARVE_MAX data grants.
module rv32i_arb_pick
   import rv32i_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic en,
   input  logic if_req,
   input  logic d_req,
   output logic if_gnt,
   output logic d_gnt
);

   localparam int SW = 4;
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] streak;
   logic          starve;

   always_comb begin
      starve = if_req && (streak == SMAX);
      d_gnt  = en && d_req && !starve;
      if_gnt = en && if_req && !d_gnt;
   end

   // streak only moves on a grant, so halt holds it
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (if_gnt) begin
         streak <= '0;
      end else if (d_gnt) begin
         if (!if_req)
            streak <= '0;
         else if (streak != SMAX)
            streak <= streak + 1'b1;
      end
   end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter for instruction fetch and load/store.
// One access in flight; reads return after MEM_LAT cycles.
module rv32i_mem_arbiter
   import rv32i_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   input  logic          halt,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   arb_state_e state, state_nxt;
   logic [2:0] lat_cnt, lat_nxt;
   logic       owner, owner_nxt;
   logic       flushed, flushed_nxt;
   logic       en;
   logic       if_pick;
   logic       d_pick;

   assign en = rst_n && (state == IDLE) && !halt;

   rv32i_arb_pick #(
      .STARVE_MAX(STARVE_MAX)
   ) u_pick (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .en     (en),
      .if_req (if_req),
      .d_req  (d_req),
      .if_gnt (if_pick),
      .d_gnt  (d_pick)
   );

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state   <= IDLE;
         lat_cnt <= '0;
         owner   <= REQ_IF;
         flushed <= 1'b0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_nxt;
         owner   <= owner_nxt;
         flushed <= flushed_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lat_nxt     = lat_cnt;
      owner_nxt   = owner;
      flushed_nxt = flushed;
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      if_rvalid   = 1'b0;
      if_rdata    = '0;
      d_rvalid    = 1'b0;
      d_rdata     = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (rst_n) begin
         unique case (state)
            IDLE: begin
               if_gnt = if_pick;
               d_gnt  = d_pick;
               unique case (1'b1)
                  d_pick: begin
                     mem_req   = 1'b1;
                     mem_we    = d_we;
                     mem_addr  = d_addr;
                     mem_wdata = d_wdata;
                  end
                  if_pick: begin
                     mem_req  = 1'b1;
                     mem_addr = if_addr;
                  end
                  default: ;
               endcase
               // stores finish at issue; only reads wait
               if (if_pick || (d_pick && !d_we)) begin
                  state_nxt = RD_WAIT;
                  lat_nxt   = LAT;
                  owner_nxt = d_pick ? REQ_D : REQ_IF;
               end
            end
            RD_WAIT: begin
               lat_nxt = lat_cnt - 3'd1;
               if (owner == REQ_IF && if_flush)
                  flushed_nxt = 1'b1;
               if (lat_cnt == 3'd1) begin
                  state_nxt   = IDLE;
                  flushed_nxt = 1'b0;
                  if (owner == REQ_D) begin
                     d_rvalid = 1'b1;
                     d_rdata  = mem_rdata;
                  end else if (!flushed && !if_flush) begin
                     if_rvalid = 1'b1;
                     if_rdata  = mem_rdata;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Randomized bench for rv32i_mem_arbiter against a cycle-indexed
// transaction model and a bench-side memory device.
module tb_rv32i_mem_arbiter;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          halt;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk1 = ~clk1;

   rv32i_mem_arbiter #(
      .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .halt      (halt),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [DW-1:0] ref_mem [1024];
   logic [DW-1:0] dev_mem [1024];
   int            dev_due = -1;
   logic [AW-1:0] dev_addr;

   bit            pend_v;
   bit            pend_d;
   bit            pend_fl;
   int            pend_rc;
   logic [DW-1:0] pend_data;
   int            streak_m;
   bit            drop_if;
   bit            drop_d;
   int            n_ifg;
   int            n_dg;
   int            n_irv;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input int p_if, input int p_d, input int p_we,
                       input int p_fl, input int p_halt, input int p_rst);
      bit            busy;
      bit            e_ig, e_dg, e_irv, e_drv, e_mreq, e_mwe;
      logic [AW-1:0] e_maddr;
      logic [DW-1:0] e_mwdata;
      @(negedge clk1);
      if (drop_if) if_req = 1'b0;
      if (drop_d)  d_req  = 1'b0;
      rst_n    = !(int'($urandom_range(99)) < p_rst);
      halt     = int'($urandom_range(99)) < p_halt;
      if_flush = int'($urandom_range(99)) < p_fl;
      if (!if_req && int'($urandom_range(99)) < p_if) begin
         if_req  = 1'b1;
         if_addr = AW'($urandom);
      end
      if (!d_req && int'($urandom_range(99)) < p_d) begin
         d_req   = 1'b1;
         d_we    = int'($urandom_range(99)) < p_we;
         d_addr  = AW'($urandom);
         d_wdata = $urandom;
      end
      mem_rdata = (cyc == dev_due) ? dev_mem[dev_addr] : $urandom;
      #1;
      e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0;
      e_mreq = 0; e_mwe = 0; e_maddr = '0; e_mwdata = '0;
      if (rst_n) begin
         busy = pend_v && (cyc <= pend_rc);
         if (busy) begin
            if (!pend_d && if_flush) pend_fl = 1;
            if (cyc == pend_rc) begin
               if (pend_d) e_drv = 1;
               else        e_irv = !pend_fl;
            end
         end else if (!halt) begin
            if (d_req && !(if_req && streak_m == SMAX)) e_dg = 1;
            else if (if_req)                            e_ig = 1;
         end
      end
      if (e_dg) begin
         e_mreq = 1; e_mwe = d_we; e_maddr = d_addr; e_mwdata = d_wdata;
      end else if (e_ig) begin
         e_mreq = 1; e_maddr = if_addr;
      end
      chk("if_gnt",    if_gnt,    e_ig);
      chk("d_gnt",     d_gnt,     e_dg);
      chk("mem_req",   mem_req,   e_mreq);
      chk("mem_we",    mem_we,    e_mwe);
      chk("mem_addr",  mem_addr,  e_maddr);
      chk("mem_wdata", mem_wdata, e_mwdata);
      chk("if_rvalid", if_rvalid, e_irv);
      chk("d_rvalid",  d_rvalid,  e_drv);
      if (e_irv) chk("if_rdata", if_rdata, pend_data);
      if (e_drv) chk("d_rdata",  d_rdata,  pend_data);
      if (!rst_n) begin
         chk("rst_if_rdata", if_rdata, '0);
         chk("rst_d_rdata",  d_rdata,  '0);
      end
      n_ifg += int'(e_ig);
      n_dg  += int'(e_dg);
      n_irv += int'(e_irv);
      if (!rst_n) begin
         pend_v   = 0;
         streak_m = 0;
      end else if (e_dg) begin
         streak_m = if_req ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
         if (d_we) begin
            ref_mem[d_addr] = d_wdata;
         end else begin
            pend_v = 1; pend_d = 1; pend_fl = 0;
            pend_rc = cyc + LAT; pend_data = ref_mem[d_addr];
         end
      end else if (e_ig) begin
         streak_m = 0;
         pend_v = 1; pend_d = 0; pend_fl = 0;
         pend_rc = cyc + LAT; pend_data = ref_mem[if_addr];
      end
      if (mem_req && mem_we) begin
         dev_mem[mem_addr] = mem_wdata;
      end else if (mem_req) begin
         dev_due  = cyc + LAT;
         dev_addr = mem_addr;
      end
      drop_if = if_gnt;
      drop_d  = d_gnt;
      @(posedge clk1);
      cyc++;
   endtask

   initial begin
      logic [DW-1:0] v;
      for (int i = 0; i < 1024; i++) begin
         v = $urandom;
         ref_mem[i] = v;
         dev_mem[i] = v;
      end
      rst_n = 0; halt = 0; if_flush = 0;
      if_req = 0; if_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0;
      pend_v = 0; pend_d = 0; pend_fl = 0; pend_rc = 0;
      pend_data = '0; streak_m = 0;
      drop_if = 0; drop_d = 0;
      n_ifg = 0; n_dg = 0; n_irv = 0;
      for (int i = 0; i < 3; i++) step(100, 100, 0, 0, 0, 100);
      for (int i = 0; i < 150; i++) step(100, 100, 0, 0, 0, 0);
      chk("starve_if_share", (n_ifg * 4 >= n_dg) ? 1 : 0, 1);
      for (int i = 0; i < 150; i++) step(70, 0, 0, 0, 0, 0);
      chk("if_reads_seen", (n_irv > 10) ? 1 : 0, 1);
      for (int i = 0; i < 200; i++) step(60, 60, 50, 25, 0, 0);
      for (int i = 0; i < 400; i++) step(60, 60, 40, 20, 15, 2);
      for (int i = 0; i < 100; i++) step(80, 80, 30, 10, 40, 5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
